// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types, default geometry and address-split helpers for the
// direct-mapped write-back data cache (dcache_sram, dcache_ctrl).
package dcache_pkg;

    localparam int WORD_W         = 32;
    localparam int DEF_NUM_LINES  = 32;
    localparam int DEF_LINE_WORDS = 8;

    // Controller states; the encoding is fixed at 0..3.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        REFILL    = 2'd3
    } state_e;

    // Tag field: everything above index and word offset.
    function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                             input int index_w,
                                             input int offset_w);
        return addr >> (2 + offset_w + index_w);
    endfunction

    // Line index field.
    function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                               input int index_w,
                                               input int offset_w);
        return (addr >> (2 + offset_w)) & ((32'd1 << index_w) - 32'd1);
    endfunction

    // Word offset inside the line; byte bits [1:0] are dropped.
    function automatic logic [31:0] addr_offset(input logic [31:0] addr,
                                                input int offset_w);
        return (addr >> 2) & ((32'd1 << offset_w) - 32'd1);
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: tag, valid, dirty and data arrays of the data cache.
// Asynchronous read of the addressed line; synchronous word and line writes.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int NUM_LINES  = DEF_NUM_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int TAG_W      = 22,
    parameter int INDEX_W    = $clog2(NUM_LINES),
    parameter int OFFSET_W   = $clog2(LINE_WORDS),
    parameter int LINE_W     = WORD_W * LINE_WORDS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  index_i,
    input  logic [OFFSET_W-1:0] offset_i,
    output logic                rd_valid_o,
    output logic                rd_dirty_o,
    output logic [TAG_W-1:0]    rd_tag_o,
    output logic [WORD_W-1:0]   rd_word_o,
    output logic [LINE_W-1:0]   rd_line_o,
    input  logic                word_we_i,
    input  logic [WORD_W-1:0]   word_data_i,
    input  logic                line_we_i,
    input  logic [TAG_W-1:0]    line_tag_i,
    input  logic [LINE_W-1:0]   line_data_i,
    input  logic                clr_dirty_i
);

    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [LINE_W-1:0]    data_mem [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;

    assign rd_valid_o = valid_q[index_i];
    assign rd_dirty_o = dirty_q[index_i];
    assign rd_tag_o   = tag_mem[index_i];
    assign rd_line_o  = data_mem[index_i];
    assign rd_word_o  = rd_line_o[WORD_W*offset_i +: WORD_W];

    // Tag and data storage: a line fill replaces tag and data, a store hit patches one word.
    // NOTE: tag/data arrays carry no reset; the valid bits alone keep stale contents unreachable.
    always_ff @(posedge clk) begin
        if (line_we_i) begin
            tag_mem[index_i]  <= line_tag_i;
            data_mem[index_i] <= line_data_i;
        end else if (word_we_i) begin
            data_mem[index_i][WORD_W*offset_i +: WORD_W] <= word_data_i;
        end
    end

    // Line state bits: fill makes a line valid and clean, a store dirties it, write-back cleans it.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we_i) begin
            valid_q[index_i] <= 1'b1;
            dirty_q[index_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[index_i] <= 1'b1;
        end else if (clr_dirty_i) begin
            dirty_q[index_i] <= 1'b0;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data-cache controller
// for the MEM stage. Hits complete with zero latency; misses raise mem_stall and
// move whole lines over a req/ack handshake (optional victim write-back, then fill).
// Optional feature: define DCACHE_STATS_EN to add the stat_hits/stat_misses counters.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES  = DEF_NUM_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cpu_req,
    input  logic                       cpu_we,
    input  logic [31:0]                cpu_addr,
    input  logic [31:0]                cpu_wdata,
    output logic [31:0]                cpu_rdata,
    output logic                       mem_stall,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [31:0]                mem_addr,
    output logic [32*LINE_WORDS-1:0]   mem_wdata,
    input  logic                       mem_ack,
    input  logic [32*LINE_WORDS-1:0]   mem_rdata
`ifdef DCACHE_STATS_EN
   ,output logic [31:0]                stat_hits,
    output logic [31:0]                stat_misses
`endif
);

    localparam int INDEX_W  = $clog2(NUM_LINES);
    localparam int OFFSET_W = $clog2(LINE_WORDS);
    localparam int TAG_W    = 32 - INDEX_W - OFFSET_W - 2;
    localparam int LINE_W   = WORD_W * LINE_WORDS;

    // Address split of the current MEM-stage access.
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic                unused_byte_bits;

    assign tag              = TAG_W'(addr_tag(cpu_addr, INDEX_W, OFFSET_W));
    assign index            = INDEX_W'(addr_index(cpu_addr, INDEX_W, OFFSET_W));
    assign offset           = OFFSET_W'(addr_offset(cpu_addr, OFFSET_W));
    assign unused_byte_bits = ^cpu_addr[1:0];

    // Line storage read port and write controls.
    logic                rd_valid;
    logic                rd_dirty;
    logic [TAG_W-1:0]    rd_tag;
    logic [WORD_W-1:0]   rd_word;
    logic [LINE_W-1:0]   rd_line;
    logic                word_we;
    logic                line_we;
    logic                clr_dirty;

    state_e              state_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [31:0]         mem_addr_q;
    logic [LINE_W-1:0]   mem_wdata_q;

    logic                hit;
    logic                acc_idle;
    logic                victim_dirty;
    logic [31:0]         fill_addr;
    logic [31:0]         victim_addr;

    assign hit          = rd_valid && (rd_tag == tag);
    assign acc_idle     = (state_q == IDLE) && cpu_req;
    assign victim_dirty = rd_valid && rd_dirty;
    assign fill_addr    = {tag, index, {(OFFSET_W+2){1'b0}}};
    assign victim_addr  = {rd_tag, index, {(OFFSET_W+2){1'b0}}};

    // Array writes are suppressed in a reset cycle so an abandoned fill leaves no trace.
    assign word_we   = !rst && acc_idle && cpu_we && hit;
    assign line_we   = !rst && (state_q == FETCH) && mem_req_q && mem_ack;
    assign clr_dirty = !rst && (state_q == WRITEBACK) && mem_req_q && mem_ack;

    // Miss is flagged in the same cycle it is seen; every service state stalls.
    assign mem_stall = (state_q != IDLE) || (cpu_req && !hit);
    assign cpu_rdata = (acc_idle && !cpu_we && hit) ? rd_word : '0;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    dcache_sram #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
    ) u_sram (
        .clk         (clk),
        .rst         (rst),
        .index_i     (index),
        .offset_i    (offset),
        .rd_valid_o  (rd_valid),
        .rd_dirty_o  (rd_dirty),
        .rd_tag_o    (rd_tag),
        .rd_word_o   (rd_word),
        .rd_line_o   (rd_line),
        .word_we_i   (word_we),
        .word_data_i (cpu_wdata),
        .line_we_i   (line_we),
        .line_tag_i  (tag),
        .line_data_i (mem_rdata),
        .clr_dirty_i (clr_dirty)
    );

    // Miss sequencing FSM with registered memory request; the request drops for
    // one cycle after every ack, including between write-back and fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req && !hit) begin
                        mem_req_q <= 1'b1;
                        if (victim_dirty) begin
                            state_q     <= WRITEBACK;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= victim_addr;
                            mem_wdata_q <= rd_line;
                        end else begin
                            state_q    <= FETCH;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= fill_addr;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_req_q && mem_ack) begin
                        state_q    <= FETCH;
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= fill_addr;
                    end
                end
                FETCH: begin
                    if (!mem_req_q) begin
                        mem_req_q <= 1'b1;
                    end else if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= REFILL;
                    end
                end
                REFILL: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic        refill_done_q;
    logic [31:0] stat_hits_q;
    logic [31:0] stat_misses_q;

    // Access statistics; the access retired right after REFILL is not a fresh hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            refill_done_q <= 1'b0;
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else begin
            refill_done_q <= (state_q == REFILL);
            if (acc_idle && hit && !refill_done_q) begin
                stat_hits_q <= stat_hits_q + 32'd1;
            end
            if (acc_idle && !hit) begin
                stat_misses_q <= stat_misses_q + 32'd1;
            end
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`endif

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data-cache controller in the MEM stage of the 5-stage pipeline.
- Produces mem_stall, which freezes the MEM/WB register and every earlier stage while a miss is serviced.
- Serves CPU loads and stores from on-chip line storage.
- Exchanges whole lines with off-chip data memory over a req/ack handshake.

Parameters:
- NUM_LINES, 32, number of cache lines (power of 2); INDEX_W = log2(NUM_LINES).
- LINE_WORDS, 8, 32-bit words per line (power of 2); OFFSET_W = log2(LINE_WORDS).
- TAG_W, 32-INDEX_W-OFFSET_W-2, derived; not overridable.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  MEM-stage access valid (MemRead | MemWrite).
- cpu_we  in  1  1 = store, 0 = load; sampled only when cpu_req = 1.
- cpu_addr  in  32  byte address; bits [1:0] are ignored.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data; valid in any cycle where cpu_req=1, cpu_we=0 and mem_stall=0.
- mem_stall  out  1  high while the current access cannot complete this cycle.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = line write-back, 0 = line fetch.
- mem_addr  out  32  line-aligned address; low OFFSET_W+2 bits are 0.
- mem_wdata  out  32*LINE_WORDS  victim line data.
- mem_ack  in  1  one-cycle pulse; the transfer completes on the edge where it is sampled high.
- mem_rdata  in  32*LINE_WORDS  fill data; valid in the mem_ack cycle.

Behaviour:
Address split and hit:
- Address fields: tag = addr[31 -: TAG_W]; index = addr[2+OFFSET_W +: INDEX_W]; word offset = addr[2 +: OFFSET_W].
- hit = valid[index] & (tag_array[index] == tag). It is combinational.

Reset:
- All valid and dirty bits are cleared; FSM goes to IDLE.
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, mem_stall=0.
- Data and tag arrays are not cleared.

FSM states IDLE, WRITEBACK, FETCH, REFILL:
- IDLE, no request or hit: mem_stall=0.
  - Load hit: cpu_rdata = selected word, combinationally (zero-latency hit).
  - Store hit: word written and dirty set at the next edge.
- IDLE, request and miss: mem_stall=1 combinationally in the same cycle.
  - Dirty victim: next state WRITEBACK.
  - Otherwise: next state FETCH.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index, 0}, mem_wdata=victim line.
  - On mem_ack: go to FETCH and clear the dirty bit.
- FETCH: mem_req=1, mem_we=0, mem_addr={tag, index, 0}.
  - On mem_ack: write mem_rdata into the line, set valid, clear dirty, write tag; go to REFILL.
- REFILL: mem_stall=1 for exactly one cycle, then return to IDLE.
  - The re-evaluated access hits in IDLE and completes as a normal hit, so a store miss merges its word then.
- mem_stall is 1 in every non-IDLE state.

Latency and protocol:
- Clean miss: stall cycles = memory latency + 2. Dirty miss adds one more memory transaction.
- mem_req, mem_we and mem_addr stay stable from assertion until the ack edge.
- mem_req drops in the cycle after the ack.
- A mem_ack while mem_req=0 is ignored.

Boundary cases:
- cpu_addr, cpu_we and cpu_wdata are held constant by the pipeline while mem_stall=1; the controller does not re-latch them.
- rst asserted mid-miss: abandons the transaction; mem_req=0 at the next edge; no array update from an ack in the reset cycle.
- A store to a valid line with a different tag evicts it (dirty → write-back first).

Optional Feature:
DCACHE_STATS_EN
- Defined: adds outputs stat_hits[31:0] and stat_misses[31:0].
  - stat_hits increments once per access completed in IDLE without a miss.
  - stat_misses increments once per IDLE→WRITEBACK/FETCH transition.
  - The REFILL-completed access is not counted as a hit.
  - Both reset to 0 on rst and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package dcache_pkg holds:
  - state enum (IDLE, WRITEBACK, FETCH, REFILL, 2-bit encoding 0..3);
  - default geometry constants;
  - the address-split helper functions (tag/index/offset).
- Sub-module dcache_sram: tag, valid, dirty and data arrays.
  - Asynchronous read, synchronous write.
  - Word-write and line-write ports.
- dcache_ctrl keeps the FSM, hit compare and memory handshake.

Test Plan:
1. Cold load 0x0000_0104, mem_ack 10 cycles after mem_req → FETCH with mem_addr=0x0000_0100; mem_stall high 12 cycles; then cpu_rdata = word 1 of mem_rdata.
2. Store 0xDEADBEEF to 0x0000_0104 after test 1, then load 0x0000_0104 → both complete with mem_stall=0; load returns 0xDEADBEEF; dirty[index 8]=1.
3. Load 0x0000_2104 (same index, new tag) after test 2 → WRITEBACK to 0x0000_0100 with mem_wdata word1=0xDEADBEEF, then FETCH 0x0000_2100; exactly two mem_req transactions.
4. Store miss to clean line at 0x0000_0040 → FETCH only, no write-back; after REFILL the word is written and the line is dirty.
5. Assert rst during FETCH, with mem_ack arriving on the same edge → next cycle IDLE, mem_req=0, mem_stall=0, valid all 0; a reload of the same address misses again.
6. DCACHE_STATS_EN defined, tests 1–3 replayed → stat_hits=2, stat_misses=2.
